tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen.sv | 129 ++++++++++++
 tb/tb_tick_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: per-channel periodic or one-shot
// pulses every D+1 cycles. Optional macro TICK_GEN_CNT_EN adds per-channel tick counters.
module tick_gen #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned CW      = 21,
  parameter int unsigned DEF_DIV = 1666666,
  parameter int unsigned CHW     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [CW-1:0]     cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_ack,
`ifdef TICK_GEN_CNT_EN
  output logic [8*NCH-1:0]  tick_total,
`endif
  output logic [NCH-1:0]    tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic cfg_ack_q;

  // Every write is acknowledged, even one addressed past the last channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_ack_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_wr;
    end
  end

  assign cfg_ack = cfg_ack_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e        st_q, st_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          tick_q, tick_d;
    logic          hit;

    assign hit = cfg_wr && (32'(cfg_ch) == i);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q   <= ST_IDLE;
        div_q  <= CW'(DEF_DIV);
        cnt_q  <= '0;
        mode_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        mode_q <= mode_d;
        tick_q <= tick_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      tick_d = 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (en[i]) st_d = ST_RUN;
        end
        ST_RUN: begin
          if (!en[i]) begin
            st_d = ST_IDLE;
          end else if (cnt_q >= div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (mode_q) st_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          cnt_d = '0;
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
      // A restart (sync or own cfg write) overrides whatever the channel would have done.
      if (sync || hit) begin
        cnt_d  = '0;
        tick_d = 1'b0;
        st_d   = en[i] ? ST_RUN : ST_IDLE;
      end
      if (hit) begin
        div_d  = cfg_div;
        mode_d = cfg_mode;
      end
    end

    assign tick[i] = tick_q;

`ifdef TICK_GEN_CNT_EN
    logic [7:0] tot_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        tot_q <= 8'd0;
      end else if (hit) begin
        tot_q <= 8'd0;
      end else if (tick_d) begin
        tot_q <= tot_q + 8'd1;
      end
    end

    assign tick_total[8*i +: 8] = tot_q;
`endif
  end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a two-channel and a one-channel instance share
// stimulus; a cycle-level reference model predicts tick/ack per edge.
module tb_tick_gen;

  logic       clk;
  logic       reset_n;
  logic [1:0] en;
  logic       sync;
  logic       cfg_wr;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic       ack_a, ack_b;
  logic [1:0] tick_a;
  logic [0:0] tick_b;
`ifdef TICK_GEN_CNT_EN
  logic [15:0] tot_a;
  logic [7:0]  tot_b;
`endif

  tick_gen #(.NCH(2), .CW(8), .DEF_DIV(4), .CHW(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cfg_ack(ack_a),
`ifdef TICK_GEN_CNT_EN
    .tick_total(tot_a),
`endif
    .tick(tick_a)
  );

  tick_gen #(.NCH(1), .CW(8), .DEF_DIV(4), .CHW(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en[0:0]), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cfg_ack(ack_b),
`ifdef TICK_GEN_CNT_EN
    .tick_total(tot_b),
`endif
    .tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [1:0]  tk_a;
    bit        ack_a;
    bit        tk_b;
    bit        ack_b;
    bit [15:0] tot_a;
    bit [7:0]  tot_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Model slots: 0,1 = two-channel instance; 2 = one-channel instance.
  int div_m[3];
  bit mode_m[3];
  bit act_m[3];
  bit done_m[3];
  int n_m[3];
  int tot_m[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) begin
      div_m[s] = 4; mode_m[s] = 1'b0; act_m[s] = 1'b0;
      done_m[s] = 1'b0; n_m[s] = 0; tot_m[s] = 0;
    end
  endfunction

  // A tick falls on every (D+1)th counting edge since the last restart;
  // the edge that starts a channel running does not count.
  function automatic bit ch_step(input int s, input bit e, input bit hit,
                                 input bit syn, input int d, input bit m);
    if (hit) begin
      div_m[s] = d; mode_m[s] = m; tot_m[s] = 0;
    end
    if (hit || syn) begin
      n_m[s] = 0; done_m[s] = 1'b0; act_m[s] = e;
      return 1'b0;
    end
    if (done_m[s]) return 1'b0;
    if (!act_m[s] || !e) begin
      act_m[s] = e;
      return 1'b0;
    end
    n_m[s]++;
    if (n_m[s] % (div_m[s] + 1) == 0) begin
      tot_m[s] = (tot_m[s] + 1) % 256;
      if (mode_m[s]) done_m[s] = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step(input bit [1:0] e, input bit s, input bit w, input bit c,
                      input int d, input bit m);
    exp_t x;
    en = e; sync = s; cfg_wr = w; cfg_ch = c; cfg_div = 8'(d); cfg_mode = m;
    x.tk_a[0] = ch_step(0, e[0], w && (c == 1'b0), s, d, m);
    x.tk_a[1] = ch_step(1, e[1], w && (c == 1'b1), s, d, m);
    x.tk_b    = ch_step(2, e[0], w && (c == 1'b0), s, d, m);
    x.ack_a   = w;
    x.ack_b   = w;
    x.tot_a   = {8'(tot_m[1]), 8'(tot_m[0])};
    x.tot_b   = 8'(tot_m[2]);
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_step();
    exp_t x;
    x = '{default: 0};
    reset_n = 1'b0;
    en = 2'b00; sync = 1'b0; cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_div = 8'd0; cfg_mode = 1'b0;
    model_reset();
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit [1:0] e, input int n);
    for (int k = 0; k < n; k++) step(e, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: one expected entry per rising edge, compared just after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("tick_a", 32'(tick_a), 32'(x.tk_a));
        chk("ack_a", 32'(ack_a), 32'(x.ack_a));
        chk("tick_b", 32'(tick_b), 32'(x.tk_b));
        chk("ack_b", 32'(ack_b), 32'(x.ack_b));
`ifdef TICK_GEN_CNT_EN
        chk("tot_a", 32'(tot_a), 32'(x.tot_a));
        chk("tot_b", 32'(tot_b), 32'(x.tot_b));
`endif
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    en = 2'b00; sync = 1'b0; cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_div = 8'd0; cfg_mode = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) rst_step();
    reset_n = 1'b1;

    // Default divisor on channel 0 only.
    idle(2'b01, 16);
    // Divisor 0: tick every cycle.
    step(2'b01, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(2'b01, 6);
    // One-shot on channel 1, then re-armed by sync.
    step(2'b11, 1'b0, 1'b1, 1'b1, 2, 1'b1);
    idle(2'b11, 8);
    step(2'b11, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(2'b11, 6);
    idle(2'b00, 2);
    idle(2'b11, 3);
    // Write landing on the wrap edge of channel 0.
    step(2'b01, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    idle(2'b01, 3);
    step(2'b01, 1'b0, 1'b1, 1'b0, 5, 1'b0);
    idle(2'b01, 8);
    // Back-to-back writes, then sync together with a write.
    step(2'b11, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    step(2'b11, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    idle(2'b11, 5);
    step(2'b11, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    idle(2'b11, 9);

    // Asynchronous reset while tick and ack are high.
    step(2'b01, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    step(2'b01, 1'b0, 1'b1, 1'b1, 6, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_tick_a", 32'(tick_a), 32'd0);
    chk("rst_ack_a", 32'(ack_a), 32'd0);
    chk("rst_tick_b", 32'(tick_b), 32'd0);
    chk("rst_ack_b", 32'(ack_b), 32'd0);
    repeat (2) rst_step();
    reset_n = 1'b1;
    idle(2'b01, 3);
    rst_step();
    reset_n = 1'b1;
    idle(2'b01, 12);

    // Randomised traffic, mostly enabled.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    // Long run at divisor 0 to exercise counter wrap.
    step(2'b01, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(2'b01, 300);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
